// File: rtl/switch_output_arbiter.sv
// Crossbar output arbiter: one round-robin FSM per output, packet-level locks held
// until the owning input signals done, plus an optional per-output hold watchdog.
module switch_output_arbiter #(
    parameter int  NUM_PORTS = 4,
    parameter int  MAX_HOLD  = 64,
    localparam int SEL_W     = $clog2(NUM_PORTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0]           done_i,
    output logic [NUM_PORTS-1:0]           grant_o,
    output logic [NUM_PORTS*SEL_W-1:0]     mux_sel_o,
    output logic [NUM_PORTS-1:0]           active_o,
    output logic [NUM_PORTS-1:0]           timeout_o,
    output logic [NUM_PORTS-1:0]           req_err_o
);

    localparam int                HOLD_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [SEL_W-1:0]  LAST_PORT = SEL_W'(NUM_PORTS - 1);
    localparam bit                WATCHDOG  = (MAX_HOLD > 0);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Per-output arbitration state.
    state_t            state    [NUM_PORTS];
    logic [SEL_W-1:0]  ptr      [NUM_PORTS];
    logic [SEL_W-1:0]  sel      [NUM_PORTS];
    logic [HOLD_W-1:0] hold_cnt [NUM_PORTS];

    logic [NUM_PORTS-1:0] cand     [NUM_PORTS];
    logic [SEL_W-1:0]     pick_idx [NUM_PORTS];
    logic [NUM_PORTS-1:0] pick_valid;
    logic [NUM_PORTS-1:0] win;
    logic [NUM_PORTS-1:0] done_hit;
    logic [NUM_PORTS-1:0] expire;
    logic [NUM_PORTS-1:0] claimed;
    logic [NUM_PORTS-1:0] grant_next;
    logic [NUM_PORTS-1:0] req_err_next;

    // cand[o][p]: idle output o sees a request from an input that owns nothing yet.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            // NOTE: every always_comb output gets a default first so no latch is inferred.
            cand[o] = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                cand[o][p] = req_i[p*NUM_PORTS + o] && !grant_o[p] && (state[o] == IDLE);
            end
        end
    end

    always_comb begin
        int s;
        s          = 0;
        pick_valid = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            pick_idx[o] = '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                s = int'(ptr[o]) + k;
                if (s >= NUM_PORTS) begin
                    s = s - NUM_PORTS;
                end
                if (!pick_valid[o] && cand[o][SEL_W'(s)]) begin
                    pick_valid[o] = 1'b1;
                    pick_idx[o]   = SEL_W'(s);
                end
            end
        end
    end

    // Outputs are visited in index order, so the lowest output claims a contested input.
    always_comb begin
        claimed    = '0;
        win        = '0;
        done_hit   = '0;
        expire     = '0;
        grant_next = grant_o;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (pick_valid[o] && !claimed[pick_idx[o]]) begin
                win[o]                   = 1'b1;
                claimed[pick_idx[o]]     = 1'b1;
                grant_next[pick_idx[o]]  = 1'b1;
            end
            done_hit[o] = (state[o] == BUSY) && done_i[sel[o]];
            expire[o]   = WATCHDOG && (state[o] == BUSY) && !done_hit[o]
                          && (hold_cnt[o] == HOLD_LAST);
            if (done_hit[o] || expire[o]) begin
                grant_next[sel[o]] = 1'b0;
            end
        end
    end

    always_comb begin
        req_err_next = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            req_err_next[p] = ($countones(req_i[p*NUM_PORTS +: NUM_PORTS]) > 1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the per-output arrays are a handful of flops, not RAM, so resetting them is cheap and required.
            for (int o = 0; o < NUM_PORTS; o++) begin
                state[o]    <= IDLE;
                ptr[o]      <= '0;
                sel[o]      <= '0;
                hold_cnt[o] <= '0;
            end
            grant_o   <= '0;
            timeout_o <= '0;
            req_err_o <= '0;
        end else begin
            grant_o   <= grant_next;
            req_err_o <= req_err_next;
            for (int o = 0; o < NUM_PORTS; o++) begin
                timeout_o[o] <= 1'b0;
                case (state[o])
                    IDLE: begin
                        if (win[o]) begin
                            state[o]    <= BUSY;
                            sel[o]      <= pick_idx[o];
                            hold_cnt[o] <= '0;
                        end
                    end
                    BUSY: begin
                        if (done_hit[o] || expire[o]) begin
                            state[o]     <= IDLE;
                            ptr[o]       <= (sel[o] == LAST_PORT) ? '0 : sel[o] + SEL_W'(1);
                            sel[o]       <= '0;
                            hold_cnt[o]  <= '0;
                            timeout_o[o] <= expire[o];
                        end else if (hold_cnt[o] != '1) begin
                            hold_cnt[o] <= hold_cnt[o] + HOLD_W'(1);
                        end
                    end
                    default: begin
                        state[o] <= IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        mux_sel_o = '0;
        active_o  = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            mux_sel_o[o*SEL_W +: SEL_W] = sel[o];
            active_o[o]                 = (state[o] == BUSY);
        end
    end

endmodule

// File: tb/tb_switch_output_arbiter.sv
// Directed bench for switch_output_arbiter (4 ports, MAX_HOLD=8): a driver queues
// the hand-computed outputs expected after each edge, a monitor pops and compares.
module tb_switch_output_arbiter;

    typedef struct packed {
        logic [3:0] grant;
        logic [7:0] sel;
        logic [3:0] active;
        logic [3:0] tout;
        logic [3:0] err;
    } exp_t;

    localparam exp_t ZERO = '0;

    logic        clk;
    logic        rst;
    logic [15:0] req_i;
    logic [3:0]  done_i;
    logic [3:0]  grant_o;
    logic [7:0]  mux_sel_o;
    logic [3:0]  active_o;
    logic [3:0]  timeout_o;
    logic [3:0]  req_err_o;

    exp_t exp_q [$];
    int   tag_q [$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cycle    = 0;

    switch_output_arbiter #(.NUM_PORTS(4), .MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .done_i    (done_i),
        .grant_o   (grant_o),
        .mux_sel_o (mux_sel_o),
        .active_o  (active_o),
        .timeout_o (timeout_o),
        .req_err_o (req_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] g, input logic [7:0] s, input logic [3:0] a,
                                input logic [3:0] t, input logic [3:0] e);
        exp_t r;
        r.grant  = g;
        r.sel    = s;
        r.active = a;
        r.tout   = t;
        r.err    = e;
        return r;
    endfunction

    task automatic check(input int tag, input exp_t got, input exp_t want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL step%0d outputs: got grant=%b sel=%h active=%b timeout=%b err=%b, want grant=%b sel=%h active=%b timeout=%b err=%b",
                     tag, got.grant, got.sel, got.active, got.tout, got.err,
                     want.grant, want.sel, want.active, want.tout, want.err);
        end
    endtask

    task automatic check_inv();
        int cnt;
        bit ok;
        ok = 1'b1;
        for (int p = 0; p < 4; p++) begin
            cnt = 0;
            for (int o = 0; o < 4; o++) begin
                if (active_o[o] === 1'b1 && mux_sel_o[o*2 +: 2] === 2'(p)) cnt++;
            end
            if ((grant_o[p] === 1'b1) ? (cnt != 1) : (cnt != 0)) ok = 1'b0;
        end
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL invariant: got grant=%b active=%b sel=%h, want each granted input selected by exactly one active output",
                      grant_o, active_o, mux_sel_o);
    endtask

    // One cycle of stimulus; want is what the outputs must show after the next edge.
    task automatic step(input logic r, input logic [15:0] req, input logic [3:0] dn, input exp_t want);
        @(negedge clk);
        rst    = r;
        req_i  = req;
        done_i = dn;
        exp_q.push_back(want);
        tag_q.push_back(cycle);
        cycle++;
    endtask

    // Inputs 0,1,3 keep requesting output 2; the winner holds 4 cycles then pulses done.
    localparam logic [15:0] RR_REQ = 16'h4044;
    task automatic rr_turn(input logic [3:0] g, input logic [7:0] s);
        repeat (4) step(1'b0, RR_REQ, 4'b0000, mk(g, s, 4'b0100, 4'b0000, 4'b0000));
        step(1'b0, RR_REQ, g, ZERO);
    endtask

    initial begin : monitor
        exp_t got;
        exp_t want;
        int   tag;
        forever begin
            @(posedge clk);
            #1;
            check_inv();
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                tag  = tag_q.pop_front();
                got  = mk(grant_o, mux_sel_o, active_o, timeout_o, req_err_o);
                check(tag, got, want);
            end
        end
    end

    initial begin : driver
        exp_t lock31;
        exp_t lock_rst;
        rst    = 1'b1;
        req_i  = '0;
        done_i = '0;

        // Reset, then single request input 2 -> output 0 (req held while busy).
        step(1'b1, 16'h0000, 4'b0000, ZERO);
        step(1'b1, 16'h0000, 4'b0000, ZERO);
        repeat (3) step(1'b0, 16'h0000, 4'b0000, ZERO);
        repeat (5) step(1'b0, 16'h0100, 4'b0000, mk(4'b0100, 8'h02, 4'b0001, 4'b0000, 4'b0000));
        step(1'b0, 16'h0000, 4'b0100, ZERO);
        // ptr[0] is now 3: inputs 2 and 3 both request output 0, input 3 must win.
        step(1'b0, 16'h1100, 4'b0000, mk(4'b1000, 8'h03, 4'b0001, 4'b0000, 4'b0000));
        step(1'b0, 16'h0000, 4'b1000, ZERO);
        // Stray done from an input that owns nothing.
        step(1'b0, 16'h0000, 4'b0010, ZERO);

        // Round-robin fairness on output 2: order 0,1,3,0,1,3 with one idle cycle between.
        rr_turn(4'b0001, 8'h00);
        rr_turn(4'b0010, 8'h10);
        rr_turn(4'b1000, 8'h30);
        rr_turn(4'b0001, 8'h00);
        rr_turn(4'b0010, 8'h10);
        rr_turn(4'b1000, 8'h30);

        // Parallel: 0->1, 1->2, 2->3, 3->0; fields for outputs 3..0 are {2,1,0,3}.
        step(1'b0, 16'h1842, 4'b0000, mk(4'b1111, 8'h93, 4'b1111, 4'b0000, 4'b0000));
        step(1'b0, 16'h0000, 4'b1111, ZERO);

        // Watchdog: input 1 -> output 3, request dropped while busy, no done.
        lock31 = mk(4'b0010, 8'h40, 4'b1000, 4'b0000, 4'b0000);
        step(1'b0, 16'h0080, 4'b0000, lock31);
        repeat (7) step(1'b0, 16'h0000, 4'b0000, lock31);
        step(1'b0, 16'h0000, 4'b0000, mk(4'b0000, 8'h00, 4'b0000, 4'b1000, 4'b0000));
        step(1'b0, 16'h0000, 4'b0000, ZERO);
        // Same lock, done arrives in the eighth busy cycle: normal release, no pulse.
        step(1'b0, 16'h0080, 4'b0000, lock31);
        repeat (7) step(1'b0, 16'h0000, 4'b0000, lock31);
        step(1'b0, 16'h0000, 4'b0010, ZERO);
        step(1'b0, 16'h0000, 4'b0000, ZERO);

        // Multi-hot: input 0 requests outputs 1 and 2; output 1 wins, output 2 stays idle.
        repeat (2) step(1'b0, 16'h0006, 4'b0000, mk(4'b0001, 8'h00, 4'b0010, 4'b0000, 4'b0001));
        step(1'b0, 16'h0000, 4'b0001, ZERO);

        // Move ptr[0] to 3, lock two outputs, reset mid-lock, then re-arbitrate from ptr 0.
        step(1'b0, 16'h0100, 4'b0000, mk(4'b0100, 8'h02, 4'b0001, 4'b0000, 4'b0000));
        step(1'b0, 16'h0000, 4'b0100, ZERO);
        lock_rst = mk(4'b1100, 8'h0E, 4'b0011, 4'b0000, 4'b0000);
        step(1'b0, 16'h2100, 4'b0000, lock_rst);
        step(1'b0, 16'h0000, 4'b0000, lock_rst);
        step(1'b1, 16'h0000, 4'b0000, ZERO);
        step(1'b0, 16'h1100, 4'b0000, mk(4'b0100, 8'h02, 4'b0001, 4'b0000, 4'b0000));
        step(1'b0, 16'h0000, 4'b0100, ZERO);
        step(1'b0, 16'h0000, 4'b0000, ZERO);

        for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/switch_output_arbiter.md
# switch_output_arbiter

Parametrised N-port crossbar output arbiter for the packet switch. Generalises the fixed 4-port common-pointer scheme to NUM_PORTS outputs with independent round-robin pointers, packet-level locking held until the owning input signals end-of-transfer, and a watchdog that force-releases a stuck lock. It sits between the per-port FIFO/FSM blocks, which raise requests and receive grants, and the output muxes, which consume `mux_sel_o` and `active_o`.

## Interface
- NUM_PORTS, 4, number of input ports and output ports (≥2).
- MAX_HOLD, 64, max cycles an output may stay locked; 0 disables the watchdog.
- SEL_W, $clog2(NUM_PORTS), width of one select field (derived, not overridden).

- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- req_i  in  NUM_PORTS*NUM_PORTS  bit [p*NUM_PORTS+o] = input p requests output o; expected one-hot per input.
- done_i  in  NUM_PORTS  bit p = input p finished its transfer (last beat); 1-cycle pulse.
- grant_o  out  NUM_PORTS  bit p = input p currently owns an output (registered).
- mux_sel_o  out  NUM_PORTS*SEL_W  field o = input index driving output o (registered).
- active_o  out  NUM_PORTS  bit o = output o locked to an input (registered).
- timeout_o  out  NUM_PORTS  bit o = 1-cycle pulse, output o force-released by watchdog.
- req_err_o  out  NUM_PORTS  bit p = input p asserted more than one output request this cycle (registered).

## Operation
- Per output o: FSM IDLE/BUSY, round-robin pointer ptr[o] (SEL_W bits), hold counter hold_cnt[o] ($clog2(MAX_HOLD+1) bits).
- IDLE: candidates = inputs p with req[p][o]=1 and grant_o[p]=0. Pick the first candidate scanning ptr[o], ptr[o]+1, … modulo NUM_PORTS. If a candidate exists: go BUSY, mux_sel_o[o]=p, active_o[o]=1, grant_o[p]=1, hold_cnt=0.
- Cross-output conflict (same input picked by two outputs in one cycle, only possible with multi-hot req): lowest-index output wins; the others stay IDLE and retry next cycle.
- BUSY: ignore req_i for this output; increment hold_cnt each cycle (saturating).
- Release on done_i[mux_sel_o[o]]=1: next cycle IDLE, active_o[o]=0, grant_o[p]=0, ptr[o]=(p+1) mod NUM_PORTS.
- Watchdog (MAX_HOLD>0): if hold_cnt reaches MAX_HOLD-1 with no done, release as above and pulse timeout_o[o] in the same cycle the release becomes visible.
- done and watchdog expiry in the same cycle: treated as a normal done; no timeout pulse.
- done_i[p] while input p is not granted: ignored.
- Request deasserted while BUSY: lock held until done or timeout; done is authoritative.
- req_err_o[p] = popcount(req[p]) > 1, registered, no effect on arbitration beyond the conflict rule.
- Pointers advance only on release, never on idle cycles.

## Timing
- Reset (rst=1 at clock edge): all FSMs IDLE, ptr=0, hold_cnt=0; grant_o, mux_sel_o, active_o, timeout_o, req_err_o all 0 on the following cycle. Reset mid-transfer drops every lock immediately with no timeout pulse.
- Grant latency: req sampled at edge t → grant_o/active_o/mux_sel_o valid after edge t+1.
- Release latency: done sampled at edge t → active_o/grant_o low after edge t+1; the output is IDLE in that cycle and can re-grant, visible after edge t+2 (one-cycle bubble minimum).
- Lock duration with watchdog: active_o high for exactly MAX_HOLD cycles when done never arrives.
- Invariants (asserted by bench): active_o[o] ⇒ grant_o[mux_sel_o[o]]; an input is selected by at most one active output; grant_o[p] ⇒ exactly one active output selects p.

## Test plan
- Single request: reset, req input 2→output 0 at cycle 5 → cycle 6 active_o[0]=1, mux_sel_o[0]=2, grant_o=4'b0100; done_i[2] at cycle 10 → cycle 11 all zero, ptr[0]=3.
- Round-robin fairness: inputs 0,1,3 all request output 2 continuously, each pulses done 3 cycles after grant → grant order 0,1,3,0,1,3 with 1-cycle gaps.
- Parallel non-conflicting: inputs 0→1, 1→2, 2→3, 3→0 simultaneously → all four outputs active next cycle, grant_o=4'b1111, mux_sel_o fields {2,1,0,3} for outputs 3..0.
- Watchdog: MAX_HOLD=8, input 1 granted output 3, no done → active_o[3] high exactly 8 cycles, timeout_o[3] pulses once on release; done arriving on cycle 8 instead → no pulse.
- Multi-hot conflict: input 0 requests outputs 1 and 2 (req_i bits 1,2) → req_err_o[0]=1 next cycle, only output 1 granted to input 0, output 2 stays idle.
- Reset mid-lock: rst high while two outputs BUSY → next cycle all outputs 0, ptrs 0; fresh request granted with normal 1-cycle latency.
